mem_narrow_to_wide: RTL and testbench
=====================================

Name: mem_narrow_to_wide

Overview:
Upsizes a narrow memory port (NarrowDataWidth) onto the wide req/gnt, rvalid/rready port of the bank splitter, which sits directly downstream.
- Each narrow request becomes exactly one wide request. Write data is replicated across all lanes and the strobe is confined to the addressed lane.
- A lane-index FIFO tracks outstanding transactions. On response, the addressed lane is extracted from the wide read data.
- Unaddressed lanes carry zero strobe, so a downstream splitter built with hidden zero-strobe writes suppresses those banks.

Parameters:
AddrWidth, 32, byte address width.
NarrowDataWidth, 32, narrow data width; power of two, ≥8.
WideDataWidth, 128, wide data width; power of two, integer multiple of NarrowDataWidth.
MaxTrans, 4, maximum outstanding transactions (depth of the lane FIFO), ≥1.

Ports:
clk_i  in  1  clock.
rst_i  in  1  reset, asynchronous, active-high.
req_i  in  1  narrow request valid.
gnt_o  out  1  narrow request granted.
addr_i  in  AddrWidth  narrow byte address.
we_i  in  1  write enable.
wdata_i  in  NarrowDataWidth  write data.
strb_i  in  NarrowDataWidth/8  byte strobe.
rvalid_o  out  1  response valid (reads and writes).
rready_i  in  1  response ready.
rdata_o  out  NarrowDataWidth  read data.
busy_o  out  1  at least one transaction outstanding.
wide_req_o  out  1  wide request valid.
wide_gnt_i  in  1  wide request granted.
wide_addr_o  out  AddrWidth  wide-aligned byte address.
wide_we_o  out  1  write enable.
wide_wdata_o  out  WideDataWidth  replicated write data.
wide_strb_o  out  WideDataWidth/8  lane-positioned strobe.
wide_rvalid_i  in  1  wide response valid.
wide_rready_o  out  1  wide response ready.
wide_rdata_i  in  WideDataWidth  wide read data.

Behaviour:
- Constants and address decoding:
  - Lanes = WideDataWidth/NarrowDataWidth.
  - LaneBits = clog2(Lanes). Lanes=1 degenerates to a pass-through with tracking.
  - NarrowOff = clog2(NarrowDataWidth/8); WideOff = clog2(WideDataWidth/8).
  - lane = addr_i[WideOff-1:NarrowOff].
  - Address bits below NarrowOff are ignored (address forced narrow-aligned).
- Request path (combinational from inputs and the registered FIFO state):
  - wide_req_o = req_i & !full.
  - gnt_o = req_i & wide_gnt_i & !full.
  - wide_addr_o = addr_i with bits [WideOff-1:0] zeroed.
  - wide_wdata_o = wdata_i replicated Lanes times.
  - wide_strb_o = strb_i at lane, zero elsewhere; this is driven for reads too.
  - wide_we_o = we_i.
- Push and full:
  - On req_i & gnt_o, lane is pushed into the lane FIFO (MaxTrans entries, not fall-through).
  - full is the registered FIFO state. With the FIFO full, no request is raised even if a pop happens in the same cycle; the grant resumes the next cycle.
- Response path:
  - rvalid_o = wide_rvalid_i & !empty.
  - wide_rready_o = rready_i & !empty.
  - rdata_o = wide_rdata_i lane selected by the FIFO head.
  - Pop on rvalid_o & rready_i.
  - Write responses pass through unchanged and also pop.
  - rdata_o for write responses is the selected lane; its value is don't-care.
- Push and pop in the same cycle: legal, usage unchanged.
- Ordering: responses are in order. The FIFO is the sole ordering state; no reordering is supported.
- Usage and busy:
  - Usage counter spans 0..MaxTrans with wrapping read/write pointers.
  - busy_o = !empty, registered-state derived.
- Protocol checks:
  - wide_rvalid_i while empty is a protocol violation: assertion fires, nothing is popped, rvalid_o stays 0.
  - A held request (req_i without gnt_o) must keep addr, we, wdata and strb stable; this is asserted.
- Reset:
  - Pointers and usage are cleared and the FIFO is empty.
  - busy_o=0, rvalid_o=0 and wide_rready_o=0 immediately (asynchronous).
  - gnt_o and wide_req_o follow req_i combinationally.
  - Reset mid-operation discards in-flight tracking. Downstream must be reset concurrently.
- Elaboration checks: parameter constraints are checked at elaboration and are fatal on violation.

Decomposition:
- Shared package (mem_island_pkg):
  - lane-index width function;
  - align function (addr, offset bits);
  - strobe lane-shift function.
- One sub-module: mem_lane_fifo. It is a parametric-depth, non-fall-through FIFO with push, pop, full, empty and usage outputs, reused by other tracking stages.
- Lane replication and lane selection stay inline as generate loops.

Test Plan:
- Narrow=32, Wide=128: write addr 0x1008, strb 0xF, wdata 0xA5A5_0001, wide_gnt_i=1 -> wide_addr_o=0x1000, wide_strb_o=0x0F00, wide_wdata_o=4×0xA5A5_0001, gnt_o=1 same cycle; the write response pops and rvalid_o=1.
- Read addr 0x200C, then wide_rdata_i=0x44443333_22221111_... with lane 3 = 0xDEADBEEF -> rdata_o=0xDEADBEEF; address 0x200E yields the same lane (low bits ignored).
- MaxTrans=4, four reads granted, no responses -> fifth request: wide_req_o=0, gnt_o=0, busy_o=1. Return one response with rready_i=1 -> grant reappears next cycle, not in the pop cycle.
- Back-to-back reads to lanes 2,0,1 with responses delayed 3 cycles and rready_i toggling 1/0 -> rdata_o lanes taken in order 2,0,1; no pop while rready_i=0; wide_rready_o mirrors rready_i.
- Push and pop in the same cycle at usage 2 -> usage stays 2. Spurious wide_rvalid_i while empty -> rvalid_o=0 and assertion fires.
- Assert rst_i asynchronously with 3 outstanding -> busy_o=0 and rvalid_o=0 without waiting for a clock edge; after release the first read is tracked from an empty FIFO.

Source files
------------

// File: rtl/mem_island_pkg.sv
// Shared helpers for the memory island: lane index sizing, address alignment and
// strobe lane placement.
package mem_island_pkg;

   localparam int unsigned MaxAddrW = 64;
   localparam int unsigned MaxStrbW = 256;

   // A single lane still needs a 1-bit index so the tracking FIFO has a width.
   function automatic int unsigned lane_idx_w(input int unsigned lanes);
      return (lanes > 1) ? $clog2(lanes) : 1;
   endfunction

   function automatic logic [MaxAddrW-1:0] align(input logic [MaxAddrW-1:0] addr,
                                                 input int unsigned off);
      return addr & ~((MaxAddrW'(1) << off) - MaxAddrW'(1));
   endfunction

   function automatic logic [MaxStrbW-1:0] lane_strb(input logic [MaxStrbW-1:0] strb,
                                                     input int unsigned lane,
                                                     input int unsigned nbytes);
      return strb << (lane * nbytes);
   endfunction

endpackage

// File: rtl/mem_lane_fifo.sv
// Parametric-depth, non-fall-through FIFO with wrapping pointers and a usage count.
module mem_lane_fifo #(
   parameter int unsigned Width = 2,
   parameter int unsigned Depth = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         push_i,
   input  logic                         pop_i,
   input  logic [Width-1:0]             data_i,
   output logic [Width-1:0]             data_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [$clog2(Depth+1)-1:0]   usage_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth+1);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CntW-1:0]  usage_q, usage_d;
   logic             push, pop;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth-1)) ? '0 : p + PtrW'(1);
   endfunction

   assign full_o  = (usage_q == CntW'(Depth));
   assign empty_o = (usage_q == '0);
   assign usage_o = usage_q;
   assign push    = push_i & ~full_o;
   assign pop     = pop_i & ~empty_o;
   assign data_o  = mem_q[rptr_q];

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      usage_d = usage_q;
      if (push) wptr_d = ptr_inc(wptr_q);
      if (pop)  rptr_d = ptr_inc(rptr_q);
      case ({push, pop})
         2'b10:   usage_d = usage_q + CntW'(1);
         2'b01:   usage_d = usage_q - CntW'(1);
         default: usage_d = usage_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         usage_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         usage_q <= usage_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wptr_q] <= data_i;
   end

endmodule

// File: rtl/mem_narrow_to_wide.sv
// Upsizes a narrow req/gnt memory port onto a wide port; one wide beat per narrow
// request, with the addressed lane tracked in order for response extraction.
module mem_narrow_to_wide
   import mem_island_pkg::*;
#(
   parameter int unsigned AddrWidth       = 32,
   parameter int unsigned NarrowDataWidth = 32,
   parameter int unsigned WideDataWidth   = 128,
   parameter int unsigned MaxTrans        = 4
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           req_i,
   output logic                           gnt_o,
   input  logic [AddrWidth-1:0]           addr_i,
   input  logic                           we_i,
   input  logic [NarrowDataWidth-1:0]     wdata_i,
   input  logic [NarrowDataWidth/8-1:0]   strb_i,
   output logic                           rvalid_o,
   input  logic                           rready_i,
   output logic [NarrowDataWidth-1:0]     rdata_o,
   output logic                           busy_o,
   output logic                           wide_req_o,
   input  logic                           wide_gnt_i,
   output logic [AddrWidth-1:0]           wide_addr_o,
   output logic                           wide_we_o,
   output logic [WideDataWidth-1:0]       wide_wdata_o,
   output logic [WideDataWidth/8-1:0]     wide_strb_o,
   input  logic                           wide_rvalid_i,
   output logic                           wide_rready_o,
   input  logic [WideDataWidth-1:0]       wide_rdata_i
);

   localparam int unsigned Lanes     = WideDataWidth / NarrowDataWidth;
   localparam int unsigned LaneW     = lane_idx_w(Lanes);
   localparam int unsigned NarrowB   = NarrowDataWidth / 8;
   localparam int unsigned WideB     = WideDataWidth / 8;
   localparam int unsigned NarrowOff = $clog2(NarrowB);
   localparam int unsigned WideOff   = $clog2(WideB);

   if (NarrowDataWidth < 8 || (NarrowDataWidth & (NarrowDataWidth - 1)) != 0 ||
       (WideDataWidth & (WideDataWidth - 1)) != 0 || WideDataWidth < NarrowDataWidth ||
       MaxTrans < 1 || AddrWidth > MaxAddrW || AddrWidth <= WideOff ||
       WideB > MaxStrbW) begin : g_bad_param
      $fatal(1, "mem_narrow_to_wide: illegal parameter combination");
   end

   logic [LaneW-1:0] lane, head;
   logic             full, empty, push, pop;
   logic [$clog2(MaxTrans+1)-1:0] usage;

   if (Lanes > 1) begin : g_lane_idx
      assign lane = addr_i[WideOff-1:NarrowOff];
   end else begin : g_lane_idx_one
      assign lane = '0;
   end

   assign wide_req_o  = req_i & ~full;
   assign gnt_o       = req_i & wide_gnt_i & ~full;
   assign wide_addr_o = AddrWidth'(align(MaxAddrW'(addr_i), WideOff));
   assign wide_we_o   = we_i;
   // Strobe is positioned for reads too so the splitter sees a single active lane.
   assign wide_strb_o = WideB'(lane_strb(MaxStrbW'(strb_i), 32'(lane), NarrowB));

   for (genvar l = 0; l < Lanes; l++) begin : g_wdata
      assign wide_wdata_o[l*NarrowDataWidth +: NarrowDataWidth] = wdata_i;
   end

   if (Lanes > 1) begin : g_rsel
      logic [NarrowDataWidth-1:0] rd_lane [Lanes];
      for (genvar l = 0; l < Lanes; l++) begin : g_rd
         assign rd_lane[l] = wide_rdata_i[l*NarrowDataWidth +: NarrowDataWidth];
      end
      assign rdata_o = rd_lane[head];
   end else begin : g_rsel_one
      assign rdata_o = wide_rdata_i[NarrowDataWidth-1:0];
   end

   assign rvalid_o      = wide_rvalid_i & ~empty;
   assign wide_rready_o = rready_i & ~empty;
   assign busy_o        = ~empty;
   assign push          = gnt_o;
   assign pop           = rvalid_o & rready_i;

   mem_lane_fifo #(
      .Width (LaneW),
      .Depth (MaxTrans)
   ) u_lane_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .pop_i   (pop),
      .data_i  (lane),
      .data_o  (head),
      .full_o  (full),
      .empty_o (empty),
      .usage_o (usage)
   );

   a_no_spurious_rvalid : assert property (@(posedge clk_i) disable iff (rst_i)
      wide_rvalid_i |-> !empty);

   a_held_req_stable : assert property (@(posedge clk_i) disable iff (rst_i)
      (req_i && !gnt_o) |=> (!req_i || $stable({addr_i, we_i, wdata_i, strb_i})));

   a_usage_bound : assert property (@(posedge clk_i) disable iff (rst_i)
      32'(usage) <= MaxTrans);

endmodule

// File: tb/tb_mem_narrow_to_wide.sv
// Bench for mem_narrow_to_wide: directed vector table, multi-cycle corner sequences
// and random traffic checked against a queue-based lane-tracking model.
module tb_mem_narrow_to_wide;

   localparam int MT = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         req, we, wgnt, wrv, rready;
   logic [31:0]  addr, wdata;
   logic [3:0]   strb;
   logic [127:0] wrdata;

   logic         gnt_o, rvalid_o, busy_o, wide_req_o, wide_we_o, wide_rready_o;
   logic [31:0]  rdata_o, wide_addr_o;
   logic [127:0] wide_wdata_o;
   logic [15:0]  wide_strb_o;

   always #5 clk = ~clk;

   mem_narrow_to_wide dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .req_i         (req),
      .gnt_o         (gnt_o),
      .addr_i        (addr),
      .we_i          (we),
      .wdata_i       (wdata),
      .strb_i        (strb),
      .rvalid_o      (rvalid_o),
      .rready_i      (rready),
      .rdata_o       (rdata_o),
      .busy_o        (busy_o),
      .wide_req_o    (wide_req_o),
      .wide_gnt_i    (wgnt),
      .wide_addr_o   (wide_addr_o),
      .wide_we_o     (wide_we_o),
      .wide_wdata_o  (wide_wdata_o),
      .wide_strb_o   (wide_strb_o),
      .wide_rvalid_i (wrv),
      .wide_rready_o (wide_rready_o),
      .wide_rdata_i  (wrdata)
   );

   int nvec = 0;
   int nmis = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Outstanding-transaction model: lane and direction of each accepted request.
   typedef struct { int lane; bit we; } trk_t;
   trk_t q[$];
   bit   held = 0;

   task automatic idle();
      req = 0; addr = '0; we = 0; wdata = '0; strb = '0;
      wgnt = 0; wrv = 0; wrdata = '0; rready = 0;
   endtask

   task automatic rd(input logic [31:0] a);
      req = 1; addr = a; we = 0; wdata = '0; strb = 4'h0; wgnt = 1;
   endtask

   // Check every output for the current inputs, then advance one clock.
   task automatic cyc();
      bit full, empty, eg, erv;
      int lane;
      #1;
      full  = (q.size() == MT);
      empty = (q.size() == 0);
      lane  = (addr % 16) / 4;
      eg    = req && wgnt && !full;
      erv   = wrv && !empty;
      chk("wide_req", 128'(wide_req_o), 128'(req && !full));
      chk("gnt", 128'(gnt_o), 128'(eg));
      if (req) begin
         chk("wide_addr", 128'(wide_addr_o), 128'(addr - (addr % 16)));
         chk("wide_strb", 128'(wide_strb_o), 128'(16'(strb) << (lane * 4)));
         chk("wide_wdata", wide_wdata_o, {wdata, wdata, wdata, wdata});
         chk("wide_we", 128'(wide_we_o), 128'(we));
      end
      chk("rvalid", 128'(rvalid_o), 128'(erv));
      chk("wide_rready", 128'(wide_rready_o), 128'(rready && !empty));
      chk("busy", 128'(busy_o), 128'(!empty));
      chk("usage", 128'(dut.usage), 128'(q.size()));
      if (erv && !q[0].we)
         chk("rdata", 128'(rdata_o), 128'(32'(wrdata >> (q[0].lane * 32))));
      held = req && !eg;
      @(posedge clk);
      if (erv && rready) void'(q.pop_front());
      if (eg) q.push_back('{lane, we});
      #1;
   endtask

   typedef struct {
      logic req; logic [31:0] addr; logic we; logic [31:0] wdata; logic [3:0] strb;
      logic wgnt; logic wrv; logic [127:0] wrdata; logic rready;
      logic e_gnt; logic e_wreq; logic [31:0] e_waddr; logic [15:0] e_wstrb;
      logic e_rvalid; logic e_rready; logic e_busy; logic chk_rd; logic [31:0] e_rdata;
   } vec_t;

   vec_t tbl[11];

   localparam logic [127:0] RD  = 128'hDEADBEEF_44443333_22221111_0000AAAA;
   localparam logic [127:0] RD2 = 128'hCAFEF00D_0BADF00D_12345678_FFFFFFFF;

   initial begin
      tbl[0]  = '{1'b1, 32'h1008, 1'b1, 32'hA5A50001, 4'hF, 1'b1, 1'b0, 128'h0, 1'b0,
                  1'b1, 1'b1, 32'h1000, 16'h0F00, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
      tbl[1]  = '{1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 128'h0, 1'b1,
                  1'b0, 1'b0, 32'h0, 16'h0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0};
      tbl[2]  = '{1'b1, 32'h200C, 1'b0, 32'h0, 4'h0, 1'b1, 1'b0, 128'h0, 1'b0,
                  1'b1, 1'b1, 32'h2000, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
      tbl[3]  = '{1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, RD, 1'b1,
                  1'b0, 1'b0, 32'h0, 16'h0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF};
      tbl[4]  = '{1'b1, 32'h200E, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0, 128'h0, 1'b0,
                  1'b1, 1'b1, 32'h2000, 16'hF000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
      tbl[5]  = '{1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, RD, 1'b1,
                  1'b0, 1'b0, 32'h0, 16'h0, 1'b1, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF};
      tbl[6]  = '{1'b1, 32'h3004, 1'b0, 32'h0, 4'h3, 1'b0, 1'b0, 128'h0, 1'b0,
                  1'b0, 1'b1, 32'h3000, 16'h0030, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
      tbl[7]  = '{1'b1, 32'h3004, 1'b0, 32'h0, 4'h3, 1'b1, 1'b0, 128'h0, 1'b0,
                  1'b1, 1'b1, 32'h3000, 16'h0030, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
      tbl[8]  = '{1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, RD2, 1'b0,
                  1'b0, 1'b0, 32'h0, 16'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h12345678};
      tbl[9]  = '{1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, RD2, 1'b1,
                  1'b0, 1'b0, 32'h0, 16'h0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h12345678};
      tbl[10] = '{1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 128'h0, 1'b0,
                  1'b0, 1'b0, 32'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};

      // Reset state; request path stays combinational while in reset.
      idle();
      rst = 1; req = 1; wgnt = 1; wrv = 1; rready = 1;
      #3;
      chk("rst_gnt", 128'(gnt_o), 128'(1));
      chk("rst_wide_req", 128'(wide_req_o), 128'(1));
      chk("rst_busy", 128'(busy_o), 128'(0));
      chk("rst_rvalid", 128'(rvalid_o), 128'(0));
      chk("rst_wide_rready", 128'(wide_rready_o), 128'(0));
      idle();
      @(posedge clk); #1;
      rst = 0;
      @(posedge clk); #1;

      foreach (tbl[i]) begin
         req = tbl[i].req; addr = tbl[i].addr; we = tbl[i].we; wdata = tbl[i].wdata;
         strb = tbl[i].strb; wgnt = tbl[i].wgnt; wrv = tbl[i].wrv;
         wrdata = tbl[i].wrdata; rready = tbl[i].rready;
         #1;
         chk($sformatf("t%0d_gnt", i), 128'(gnt_o), 128'(tbl[i].e_gnt));
         chk($sformatf("t%0d_wide_req", i), 128'(wide_req_o), 128'(tbl[i].e_wreq));
         chk($sformatf("t%0d_wide_addr", i), 128'(wide_addr_o), 128'(tbl[i].e_waddr));
         chk($sformatf("t%0d_wide_strb", i), 128'(wide_strb_o), 128'(tbl[i].e_wstrb));
         chk($sformatf("t%0d_wide_wdata", i), wide_wdata_o,
             {tbl[i].wdata, tbl[i].wdata, tbl[i].wdata, tbl[i].wdata});
         chk($sformatf("t%0d_rvalid", i), 128'(rvalid_o), 128'(tbl[i].e_rvalid));
         chk($sformatf("t%0d_wide_rready", i), 128'(wide_rready_o), 128'(tbl[i].e_rready));
         chk($sformatf("t%0d_busy", i), 128'(busy_o), 128'(tbl[i].e_busy));
         if (tbl[i].chk_rd)
            chk($sformatf("t%0d_rdata", i), 128'(rdata_o), 128'(tbl[i].e_rdata));
         @(posedge clk); #1;
      end

      // Fill to MaxTrans, stall the fifth, pop one: grant returns only the cycle after.
      idle();
      for (int i = 0; i < MT; i++) begin rd(32'h4000 + 32'(i * 4)); cyc(); end
      rd(32'h5000);
      #1;
      chk("full_wide_req", 128'(wide_req_o), 128'(0));
      chk("full_gnt", 128'(gnt_o), 128'(0));
      chk("full_busy", 128'(busy_o), 128'(1));
      cyc();
      wrv = 1; rready = 1; wrdata = {$urandom, $urandom, $urandom, $urandom};
      #1;
      chk("pop_cycle_gnt", 128'(gnt_o), 128'(0));
      chk("pop_cycle_rvalid", 128'(rvalid_o), 128'(1));
      cyc();
      wrv = 0;
      #1;
      chk("after_pop_gnt", 128'(gnt_o), 128'(1));
      cyc();
      idle();
      rready = 1;
      while (q.size() != 0) begin
         wrv = 1; wrdata = {$urandom, $urandom, $urandom, $urandom}; cyc();
      end
      idle();

      // Lanes 2,0,1 back to back, responses after a gap with rready toggling.
      rd(32'h6008); cyc();
      rd(32'h6000); cyc();
      rd(32'h6004); cyc();
      idle();
      for (int i = 0; i < 3; i++) cyc();
      for (int i = 0; i < 6; i++) begin
         wrv = (q.size() != 0); rready = (i % 2 == 0);
         wrdata = {$urandom, $urandom, $urandom, $urandom};
         cyc();
      end
      idle();

      // Push and pop together at usage 2.
      rd(32'h6100); cyc();
      rd(32'h6104); cyc();
      rd(32'h6108); wrv = 1; rready = 1; wrdata = {$urandom, $urandom, $urandom, $urandom};
      cyc();
      idle();
      rready = 1;
      while (q.size() != 0) begin
         wrv = 1; wrdata = {$urandom, $urandom, $urandom, $urandom}; cyc();
      end
      idle();

      // Asynchronous reset with three outstanding.
      rd(32'h7000); cyc();
      rd(32'h7004); cyc();
      rd(32'h7008); cyc();
      idle();
      wrv = 1; rready = 1;
      #1;
      chk("pre_rst_rvalid", 128'(rvalid_o), 128'(1));
      #2;
      rst = 1;
      #1;
      chk("async_busy", 128'(busy_o), 128'(0));
      chk("async_rvalid", 128'(rvalid_o), 128'(0));
      chk("async_wide_rready", 128'(wide_rready_o), 128'(0));
      q.delete();
      idle();
      @(posedge clk); #1;
      rst = 0;
      rd(32'h700C); cyc();
      idle();
      wrv = 1; rready = 1; wrdata = {$urandom, $urandom, $urandom, $urandom};
      cyc();
      idle();
      cyc();

      // Random traffic; a stalled request is held unchanged until granted.
      held = 0;
      for (int n = 0; n < 400; n++) begin
         if (!held) begin
            req   = ($urandom_range(0, 1) == 1);
            addr  = $urandom;
            we    = ($urandom_range(0, 1) == 1);
            wdata = $urandom;
            strb  = 4'($urandom);
         end
         wgnt   = ($urandom_range(0, 9) < 7);
         wrv    = (q.size() != 0) && ($urandom_range(0, 2) != 0);
         rready = ($urandom_range(0, 3) != 0);
         wrdata = {$urandom, $urandom, $urandom, $urandom};
         cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
